dual_input_debouncer: RTL and testbench

- Conditioning stage directly upstream of the two-input sequence-detector FSM.
- Takes two raw, asynchronous, bouncy switch/button signals, synchronises them to clk and debounces them.
- Drives clean levels `a` and `b` straight into the FSM's `a` and `b` inputs.
- Also provides one-cycle edge pulses per channel for counters and LEDs elsewhere on the board.

---
 rtl/debounce_pkg.sv | 16 +
 rtl/debounce_channel.sv | 114 +++++++++++
 rtl/dual_input_debouncer.sv | 42 ++++
 tb/tb_dual_input_debouncer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: per-channel state encoding
// and the default stability window.
package debounce_pkg;

    // Encoding chosen so bit 1 matches the committed level in the stable
    // states (ST_LO=0x, ST_HI=1x) and the waiting states sit one bit away.
    typedef enum logic [1:0] {
        ST_LO = 2'b00,
        WT_HI = 2'b01,
        ST_HI = 2'b11,
        WT_LO = 2'b10
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch input: 2-flop synchroniser, 4-state stability FSM
// with a run counter, registered level and registered rise/fall pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
    end

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             level_nx;
    logic             rise_nx;
    logic             fall_nx;

    // Bring the asynchronous raw input into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // State, counter, level and pulse registers; a reset discards any
    // partially counted transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            level <= level_nx;
            rise  <= rise_nx;
            fall  <= fall_nx;
        end
    end

    // Next-state logic: a candidate level is committed only after
    // DEBOUNCE_CYCLES consecutive synchronised samples agree with it.
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        level_nx = level;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        case (state)
            ST_LO: begin
                if (s2) begin
                    state_nx = WT_HI;
                    cnt_nx   = CNT_W'(1);
                end
            end
            WT_HI: begin
                if (!s2) begin
                    state_nx = ST_LO;
                end else if (cnt == CNT_MAX) begin
                    state_nx = ST_HI;
                    level_nx = 1'b1;
                    rise_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_HI: begin
                if (!s2) begin
                    state_nx = WT_LO;
                    cnt_nx   = CNT_W'(1);
                end
            end
            WT_LO: begin
                if (s2) begin
                    state_nx = ST_HI;
                end else if (cnt == CNT_MAX) begin
                    state_nx = ST_LO;
                    level_nx = 1'b0;
                    fall_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                // Unreachable with the current encoding; kept so any
                // corrupted state falls back to a known idle condition.
                state_nx = ST_LO;
                level_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dual_input_debouncer.sv
// Two independent debounced switch channels feeding the sequence-detector
// FSM (levels a/b) plus per-channel edge pulses for board-level consumers.
module dual_input_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_a (
        .clk  (clk),
        .reset(reset),
        .raw  (a_raw),
        .level(a),
        .rise (a_rise),
        .fall (a_fall)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_b (
        .clk  (clk),
        .reset(reset),
        .raw  (b_raw),
        .level(b),
        .rise (b_rise),
        .fall (b_fall)
    );

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Scoreboard bench for dual_input_debouncer with DEBOUNCE_CYCLES=4.
module tb_dual_input_debouncer;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic a;
        logic b;
        logic ar;
        logic af;
        logic br;
        logic bf;
    } exp_t;

    exp_t sb[$];

    // reference model: run length of synchronised samples disagreeing with the level
    logic m_s1[2];
    logic m_s2[2];
    logic m_lvl[2];
    logic m_rise[2];
    logic m_fall[2];
    int   m_run[2];

    dual_input_debouncer #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a     (a),
        .b     (b),
        .a_rise(a_rise),
        .a_fall(a_fall),
        .b_rise(b_rise),
        .b_fall(b_fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic ar, input logic br, input logic rs);
        logic raw_v[2];
        logic s_now;
        raw_v[0] = ar;
        raw_v[1] = br;
        for (int ch = 0; ch < 2; ch++) begin
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            if (rs) begin
                m_s1[ch]  = 1'b0;
                m_s2[ch]  = 1'b0;
                m_lvl[ch] = 1'b0;
                m_run[ch] = 0;
            end else begin
                s_now     = m_s2[ch];
                m_s2[ch]  = m_s1[ch];
                m_s1[ch]  = raw_v[ch];
                if (s_now != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == N) begin
                        m_lvl[ch]  = s_now;
                        m_rise[ch] = s_now;
                        m_fall[ch] = !s_now;
                        m_run[ch]  = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
        end
    endtask

    // One clock of stimulus: drive at negedge, predict, return just after posedge.
    task automatic drive(input logic ar, input logic br, input logic rs);
        exp_t e;
        @(negedge clk);
        a_raw = ar;
        b_raw = br;
        reset = rs;
        model_step(ar, br, rs);
        e.a  = m_lvl[0];
        e.b  = m_lvl[1];
        e.ar = m_rise[0];
        e.af = m_fall[0];
        e.br = m_rise[1];
        e.bf = m_fall[1];
        sb.push_back(e);
        if (rs) begin
            #1;
            check("rst_async_a", a, 1'b0);
            check("rst_async_b", b, 1'b0);
            check("rst_async_arise", a_rise, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the predicted entry after each edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_a", a, e.a);
            check("sb_b", b, e.b);
            check("sb_a_rise", a_rise, e.ar);
            check("sb_a_fall", a_fall, e.af);
            check("sb_b_rise", b_rise, e.br);
            check("sb_b_fall", b_fall, e.bf);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_a;
        int first_b;
        int n_rise_a;
        int n_rise_b;
        int n_fall_a;
        int a_rise_step;
        int b_rise_step;
        logic train[10];
        logic ra;
        logic rb;

        for (int ch = 0; ch < 2; ch++) begin
            m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_lvl[ch] = 1'b0;
            m_rise[ch] = 1'b0; m_fall[ch] = 1'b0; m_run[ch] = 0;
        end
        reset = 1'b1;
        a_raw = 1'b0;
        b_raw = 1'b0;
        #1;
        check("init_a", a, 1'b0);
        check("init_b", b, 1'b0);
        check("init_pulses", {a_rise, a_fall, b_rise, b_fall}, 4'b0000);

        // Reset, then idle with raw low.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0);

        // Rise latency: level appears after the (N+2)-th step counted from the first high sample.
        first_a = 0; n_rise_a = 0; n_fall_a = 0;
        for (int j = 1; j <= 10; j++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (a && first_a == 0) first_a = j;
            n_rise_a += int'(a_rise);
            n_fall_a += int'(a_fall);
        end
        check("rise_latency", first_a, N + 2);
        check("rise_count", n_rise_a, 1);
        check("rise_no_fall", n_fall_a, 0);

        // Short low glitch (3 synchronised samples) is rejected.
        n_fall_a = 0;
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 1'b0, 1'b0);
            n_fall_a += int'(a_fall);
        end
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_fall_a += int'(a_fall);
        end
        check("glitch_lo_level", a, 1'b1);
        check("glitch_lo_nofall", n_fall_a, 0);

        // A long low commits with exactly one fall pulse.
        n_fall_a = 0;
        for (int j = 0; j < 10; j++) begin
            drive(1'b0, 1'b0, 1'b0);
            n_fall_a += int'(a_fall);
        end
        check("fall_level", a, 1'b0);
        check("fall_count", n_fall_a, 1);

        // Bounce train 1,0,1,1,0,1,1,1 then held high.
        train = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        first_a = 0; n_rise_a = 0;
        for (int i = 0; i < 16; i++) begin
            drive((i < 10) ? train[i] : 1'b1, 1'b0, 1'b0);
            if (a && first_a == 0) first_a = i - 5 + 1;
            n_rise_a += int'(a_rise);
        end
        check("bounce_latency", first_a, N + 2);
        check("bounce_rise_count", n_rise_a, 1);

        // Both channels rising together.
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0);
        a_rise_step = 0; b_rise_step = 0;
        for (int j = 1; j <= 10; j++) begin
            drive(1'b1, 1'b1, 1'b0);
            if (a_rise) a_rise_step = j;
            if (b_rise) b_rise_step = j;
        end
        check("dual_a_step", a_rise_step, N + 2);
        check("dual_b_step", b_rise_step, N + 2);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0);

        // Reset asserted mid-count, raw held high through and after reset.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        first_a = 0; n_rise_a = 0;
        for (int j = 1; j <= 10; j++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (a && first_a == 0) first_a = j;
            n_rise_a += int'(a_rise);
        end
        check("rst_mid_latency", first_a, N + 2);
        check("rst_mid_rise_count", n_rise_a, 1);

        // Reset while the level is high clears it immediately.
        check("pre_rst_level", a, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);

        // Random bouncy activity on both channels.
        ra = 1'b0; rb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) ra = ~ra;
            if ($urandom_range(0, 5) == 0) rb = ~rb;
            drive(ra, rb, 1'b0);
        end
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
